sram_like_slave: RTL and testbench

Responder end of the sram-like memory protocol driven by the CPU's instruction/data ports (req/wr/size/addr/wdata → addr_ok/data_ok/rdata). It accepts one transaction at a time and issues it to a synchronous single-port SRAM with byte write enables. It returns `data_ok` after a programmable latency so the CPU's stall logic can be exercised against realistic memory timing. One instance serves the instruction side and one serves the data side in the SoC-lite test harness.

---
 rtl/sram_like_slave.sv | 96 +++++++++
 tb/tb_sram_like_slave.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_slave.sv
// Responder end of the sram-like CPU memory protocol. It fronts a synchronous
// single-port SRAM and returns data_ok a programmable number of cycles after accept.
module sram_like_slave #(
  parameter int unsigned DELAY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        ram_en,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  localparam logic [3:0] DelayCnt = 4'(DELAY);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] rdata_q;

  logic        busy;
  logic        last;
  logic        firstBusy;
  logic        accept;
  logic [3:0]  mask;

  assign busy      = (state_q == BUSY);
  assign last      = busy && (cnt_q == DelayCnt);
  assign firstBusy = busy && (cnt_q == 4'd1);

  // A new request is taken when idle, or back-to-back in the completion cycle.
  assign addr_ok = resetn & req & (~busy | last);
  assign accept  = addr_ok;
  assign data_ok = resetn & last;

  always_comb begin
    mask = 4'b1111;
    case (size)
      2'd0:    mask = 4'b0001 << addr[1:0];
      2'd1:    mask = 4'b0011 << {addr[1], 1'b0};
      default: mask = 4'b1111;
    endcase
  end

  assign ram_en    = accept;
  assign ram_addr  = {addr[31:2], 2'b00};
  assign ram_wdata = wdata;
  assign ram_wen   = (resetn && wr) ? mask : 4'b0000;

  // SRAM data arrives during the first busy cycle; bypass it then, hold it after.
  assign rdata = firstBusy ? ram_rdata : rdata_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      if (firstBusy) begin
        rdata_q <= ram_rdata;
      end
      if (state_q == IDLE) begin
        if (accept) begin
          state_q <= BUSY;
          cnt_q   <= 4'd1;
        end
      end else begin
        if (last) begin
          if (accept) begin
            state_q <= BUSY;
            cnt_q   <= 4'd1;
          end else begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
          end
        end else begin
          cnt_q <= cnt_q + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_like_slave.sv
// Scoreboard bench for sram_like_slave: three instances (DELAY 1, 3, 4), each with
// a behavioural SRAM; a monitor checks every data_ok against queued expectations.
module tb_sram_like_slave;

  typedef struct {
    int          inst;
    logic [31:0] data;
    bit          chk;
    int          cycle;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic [2:0]  req;
  logic [2:0]  wr;
  logic [1:0]  size [3];
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic [31:0] ramRdata [3];

  wire  [2:0]  addrOk;
  wire  [2:0]  dataOk;
  wire  [2:0]  ramEn;
  wire  [3:0]  ramWen [3];
  wire  [31:0] rdata [3];
  wire  [31:0] ramAddr [3];
  wire  [31:0] ramWdata [3];

  logic [31:0] mem [3][128];
  bit          loaded = 1'b0;
  int          cyc = 0;
  int          testsRun = 0;
  int          testsFailed = 0;
  exp_t        sbQ [$];

  for (genvar g = 0; g < 3; g++) begin : gDut
    sram_like_slave #(
      .DELAY(g == 0 ? 1 : (g == 1 ? 3 : 4))
    ) u_dut (
      .clk       (clk),
      .resetn    (resetn),
      .req       (req[g]),
      .wr        (wr[g]),
      .size      (size[g]),
      .addr      (addr[g]),
      .wdata     (wdata[g]),
      .addr_ok   (addrOk[g]),
      .data_ok   (dataOk[g]),
      .rdata     (rdata[g]),
      .ram_en    (ramEn[g]),
      .ram_wen   (ramWen[g]),
      .ram_addr  (ramAddr[g]),
      .ram_wdata (ramWdata[g]),
      .ram_rdata (ramRdata[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM per instance: read-before-write, one cycle read latency.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int k = 0; k < 3; k++) begin
        for (int w = 0; w < 128; w++) mem[k][w] <= 32'd0;
        ramRdata[k] <= 32'd0;
      end
      mem[0][64] <= 32'hDEADBEEF;
      mem[1][4]  <= 32'h11111111;
      mem[1][5]  <= 32'h22222222;
      mem[2][8]  <= 32'hCAFEF00D;
      mem[2][9]  <= 32'h24242424;
      mem[2][10] <= 32'h28282828;
      mem[2][12] <= 32'h0BADF00D;
      loaded <= 1'b1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (ramEn[k]) begin
          ramRdata[k] <= mem[k][ramAddr[k][8:2]];
          for (int b = 0; b < 4; b++) begin
            if (ramWen[k][b]) mem[k][ramAddr[k][8:2]][8*b +: 8] <= ramWdata[k][8*b +: 8];
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every data_ok pops one expectation and checks instance, cycle and data.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      for (int k = 0; k < 3; k++) begin
        if (dataOk[k] === 1'b1) begin
          if (sbQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpected_data_ok: got data_ok on inst %0d at cycle %0d, expected none", k, cyc);
          end else begin
            e = sbQ.pop_front();
            checkOutput("dok_inst", 32'(k), 32'(e.inst));
            checkOutput("dok_cycle", 32'(cyc), 32'(e.cycle));
            if (e.chk) checkOutput("rdata", rdata[k], e.data);
          end
        end
      end
    end
  end

  task automatic applyStimulus(input int k, input bit isWr, input logic [1:0] sz,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] expWen, input logic [31:0] expAddr,
                               input logic [31:0] expData, input bit chk, input bit hold,
                               output int waits, output bit dokAtAccept);
    bit   accepted;
    exp_t e;
    waits       = 0;
    dokAtAccept = 1'b0;
    accepted    = 1'b0;
    @(negedge clk);
    req[k]   = 1'b1;
    wr[k]    = isWr;
    size[k]  = sz;
    addr[k]  = a;
    wdata[k] = wd;
    for (int i = 0; i < 20 && !accepted; i++) begin
      #1;
      if (addrOk[k] === 1'b1) begin
        accepted = 1'b1;
        dokAtAccept = dataOk[k];
        checkOutput("ram_en", 32'(ramEn[k]), 32'd1);
        checkOutput("ram_wen", 32'(ramWen[k]), 32'(expWen));
        checkOutput("ram_addr", ramAddr[k], expAddr);
        checkOutput("ram_wdata", ramWdata[k], wd);
        e.inst  = k;
        e.data  = expData;
        e.chk   = chk;
        e.cycle = cyc + (k == 0 ? 1 : (k == 1 ? 3 : 4));
        sbQ.push_back(e);
      end else begin
        checkOutput("ram_en_blocked", 32'(ramEn[k]), 32'd0);
        waits++;
        @(negedge clk);
      end
    end
    if (!accepted) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL accept_timeout: got no addr_ok on inst %0d, expected one within 20 cycles", k);
    end
    if (!hold) begin
      @(posedge clk);
      #1;
      req[k] = 1'b0;
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      checkOutput({tag, "_addr_ok"}, 32'(addrOk[k]), 32'd0);
      checkOutput({tag, "_data_ok"}, 32'(dataOk[k]), 32'd0);
      checkOutput({tag, "_ram_en"}, 32'(ramEn[k]), 32'd0);
      checkOutput({tag, "_ram_wen"}, 32'(ramWen[k]), 32'd0);
      checkOutput({tag, "_rdata"}, rdata[k], 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    bit d;
    resetn = 1'b0;
    req    = 3'b111;
    wr     = 3'b111;
    for (int k = 0; k < 3; k++) begin
      size[k]  = 2'd2;
      addr[k]  = 32'h100;
      wdata[k] = 32'hFFFFFFFF;
    end
    repeat (2) @(negedge clk);
    #1;
    checkResetOutputs("por");
    req = 3'b000;
    wr  = 3'b000;
    @(negedge clk);
    resetn = 1'b1;

    // DELAY=1: read, sub-word writes, then read back the merged words.
    applyStimulus(0, 1'b0, 2'd2, 32'h100, 32'h0, 4'b0000, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0, w, d);
    applyStimulus(0, 1'b1, 2'd0, 32'h103, 32'h77777777, 4'b1000, 32'h100, 32'h0, 1'b0, 1'b0, w, d);
    applyStimulus(0, 1'b1, 2'd0, 32'h101, 32'h55555555, 4'b0010, 32'h100, 32'h0, 1'b0, 1'b0, w, d);
    applyStimulus(0, 1'b1, 2'd1, 32'h6, 32'hABCDABCD, 4'b1100, 32'h4, 32'h0, 1'b0, 1'b0, w, d);
    applyStimulus(0, 1'b1, 2'd1, 32'h7, 32'h12341234, 4'b1100, 32'h4, 32'h0, 1'b0, 1'b0, w, d);
    applyStimulus(0, 1'b1, 2'd2, 32'h8, 32'hA5A5A5A5, 4'b1111, 32'h8, 32'h0, 1'b0, 1'b0, w, d);
    applyStimulus(0, 1'b1, 2'd3, 32'hB, 32'h5A5A5A5A, 4'b1111, 32'h8, 32'h0, 1'b0, 1'b0, w, d);
    applyStimulus(0, 1'b0, 2'd2, 32'h100, 32'h0, 4'b0000, 32'h100, 32'h77AD55EF, 1'b1, 1'b0, w, d);
    applyStimulus(0, 1'b0, 2'd1, 32'h4, 32'h0, 4'b0000, 32'h4, 32'h12340000, 1'b1, 1'b0, w, d);
    applyStimulus(0, 1'b0, 2'd0, 32'h8, 32'h0, 4'b0000, 32'h8, 32'h5A5A5A5A, 1'b1, 1'b0, w, d);
    repeat (3) @(negedge clk);

    // DELAY=3: req held high across two reads; second accept meets first data_ok.
    applyStimulus(1, 1'b0, 2'd2, 32'h10, 32'h0, 4'b0000, 32'h10, 32'h11111111, 1'b1, 1'b1, w, d);
    checkOutput("d3_first_waits", 32'(w), 32'd0);
    applyStimulus(1, 1'b0, 2'd2, 32'h14, 32'h0, 4'b0000, 32'h14, 32'h22222222, 1'b1, 1'b0, w, d);
    checkOutput("d3_second_waits", 32'(w), 32'd2);
    checkOutput("d3_accept_with_dok", 32'(d), 32'd1);
    checkOutput("d3_rdata_bypass", rdata[1], 32'h22222222);
    repeat (5) @(negedge clk);

    // DELAY=4: request raised one cycle after accept is held off for three cycles.
    applyStimulus(2, 1'b0, 2'd2, 32'h24, 32'h0, 4'b0000, 32'h24, 32'h24242424, 1'b1, 1'b0, w, d);
    applyStimulus(2, 1'b0, 2'd2, 32'h28, 32'h0, 4'b0000, 32'h28, 32'h28282828, 1'b1, 1'b0, w, d);
    checkOutput("d4_waits", 32'(w), 32'd3);
    checkOutput("d4_accept_with_dok", 32'(d), 32'd1);
    repeat (6) @(negedge clk);

    // Reset during the second busy cycle abandons the read with no data_ok.
    applyStimulus(2, 1'b0, 2'd2, 32'h30, 32'h0, 4'b0000, 32'h30, 32'h0BADF00D, 1'b1, 1'b0, w, d);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    void'(sbQ.pop_back());
    #1;
    req = 3'b111;
    wr  = 3'b111;
    checkResetOutputs("mid_rst");
    repeat (3) @(negedge clk);
    #1;
    checkResetOutputs("mid_rst_late");
    req = 3'b000;
    wr  = 3'b000;
    @(negedge clk);
    resetn = 1'b1;
    repeat (6) @(negedge clk);
    applyStimulus(2, 1'b0, 2'd2, 32'h20, 32'h0, 4'b0000, 32'h20, 32'hCAFEF00D, 1'b1, 1'b0, w, d);
    checkOutput("post_rst_waits", 32'(w), 32'd0);
    repeat (8) @(negedge clk);

    checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
